// File: rtl/wb_forward_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_forward_stage_if
// Brief   : Execute-side, register-file write-port and decode-forwarding
//           signal bundle for the write-back stage.
// Revision: 1.0 - initial release
// ============================================================================
interface wb_forward_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              ex_valid;
  logic              ex_write_reg;
  logic [ADDR_W-1:0] ex_rDest;
  logic [DATA_W-1:0] ex_result;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] rSrc;
  logic [DATA_W-1:0] rf_srcData;
  logic              write_reg;
  logic [ADDR_W-1:0] rDest;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] fwd_srcData;
  logic [1:0]        fwd_hit;
  logic [7:0]        retire_count;

  // Upstream / pipeline control side
  modport master (
    output ex_valid, ex_write_reg, ex_rDest, ex_result, stall, flush,
           rSrc, rf_srcData,
    input  write_reg, rDest, writeData, fwd_srcData, fwd_hit, retire_count
  );

  // Write-back stage side
  modport slave (
    input  ex_valid, ex_write_reg, ex_rDest, ex_result, stall, flush,
           rSrc, rf_srcData,
    output write_reg, rDest, writeData, fwd_srcData, fwd_hit, retire_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_forward_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_forward_stage
// Brief   : Two-slot (EX/MEM, MEM/WB) write-back pipeline driving the
//           register-file write port, forwarding in-flight results to the
//           decode operand path and counting retired instructions.
// Revision: 1.0 - initial release
// ============================================================================
module wb_forward_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  wire logic         clk,
  input  wire logic         reset,
  wb_forward_stage_if.slave bus
);

  localparam logic [1:0] c_HIT_RF = 2'b00;
  localparam logic [1:0] c_HIT_S1 = 2'b01;
  localparam logic [1:0] c_HIT_S2 = 2'b10;

  // S1 (EX/MEM) slot
  logic              r_s1_valid;
  logic              r_s1_wr;
  logic [ADDR_W-1:0] r_s1_dest;
  logic [DATA_W-1:0] r_s1_data;
  // S2 (MEM/WB) slot
  logic              r_s2_valid;
  logic              r_s2_wr;
  logic [ADDR_W-1:0] r_s2_dest;
  logic [DATA_W-1:0] r_s2_data;

  logic [7:0]        r_retire_count;

  logic [DATA_W-1:0] w_fwd_data;
  logic [1:0]        w_fwd_hit;
  logic              w_s1_match;
  logic              w_s2_match;

  // S2 advances from S1 on any non-stalled edge; flushes still let S1 retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid     <= 1'b0;
      r_s2_wr        <= 1'b0;
      r_s2_dest      <= '0;
      r_s2_data      <= '0;
      r_retire_count <= 8'd0;
    end else if (!bus.stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_wr    <= r_s1_wr;
      r_s2_dest  <= r_s1_dest;
      r_s2_data  <= r_s1_data;
      if (r_s1_valid) begin
        r_retire_count <= r_retire_count + 8'd1;
      end
    end
  end

  // S1 captures the execute result; flush empties it even during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_wr    <= 1'b0;
      r_s1_dest  <= '0;
      r_s1_data  <= '0;
    end else if (bus.flush) begin
      r_s1_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_s1_valid <= bus.ex_valid;
      r_s1_wr    <= bus.ex_write_reg;
      r_s1_dest  <= bus.ex_rDest;
      r_s1_data  <= bus.ex_result;
    end
  end

  assign w_s1_match = r_s1_valid && r_s1_wr && (r_s1_dest == bus.rSrc);
  assign w_s2_match = r_s2_valid && r_s2_wr && (r_s2_dest == bus.rSrc);

  // Operand forwarding: newest pending write to rSrc wins over older ones.
  always_comb begin
    w_fwd_data = bus.rf_srcData;
    w_fwd_hit  = c_HIT_RF;
    if (w_s1_match) begin
      w_fwd_data = r_s1_data;
      w_fwd_hit  = c_HIT_S1;
    end else if (w_s2_match) begin
      w_fwd_data = r_s2_data;
      w_fwd_hit  = c_HIT_S2;
    end
  end

  // Write port comes straight from S2 flops so it is glitch-free.
  assign bus.write_reg    = r_s2_valid & r_s2_wr;
  assign bus.rDest        = r_s2_dest;
  assign bus.writeData    = r_s2_data;
  assign bus.fwd_srcData  = w_fwd_data;
  assign bus.fwd_hit      = w_fwd_hit;
  assign bus.retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_forward_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_forward_stage
// Brief   : Self-checking bench for wb_forward_stage: directed scenarios plus
//           randomized traffic checked against an architectural-state model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_forward_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_forward_stage_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  wb_forward_stage #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the DUT write port
  logic [7:0] tb_rf [8] = '{default: 8'h00};
  logic       use_model = 1'b0;
  logic [7:0] manual_rf = 8'h00;

  always @(posedge clk) begin
    if (bus.write_reg) tb_rf[bus.rDest] <= bus.writeData;
  end

  always_comb begin
    bus.rf_srcData = use_model ? tb_rf[bus.rSrc] : manual_rf;
  end

  task automatic set_ex(input logic v, input logic w, input logic [2:0] d,
                        input logic [7:0] r);
    bus.ex_valid = v; bus.ex_write_reg = w; bus.ex_rDest = d; bus.ex_result = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    bus.stall = 1'b0; bus.flush = 1'b0;
    #20;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    use_model = 1'b0;
    reset = 1'b1;
    set_ex(1'b1, 1'b1, 3'd2, 8'hEE);
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.rSrc = 3'd2; manual_rf = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_write_reg", int'(bus.write_reg), 0);
    chk("reset_rDest", int'(bus.rDest), 0);
    chk("reset_writeData", int'(bus.writeData), 0);
    chk("reset_retire", int'(bus.retire_count), 0);
    chk("reset_fwd_hit", int'(bus.fwd_hit), 0);
    chk("reset_fwd_data", int'(bus.fwd_srcData), 'h55);
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    reset = 1'b0;
    use_model = 1'b1;
  endtask

  task automatic test_basic_write();
    do_reset();
    set_ex(1'b1, 1'b1, 3'd3, 8'hA7);
    bus.rSrc = 3'd3;
    tick();
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    chk("basic_s1_hit", int'(bus.fwd_hit), 1);
    chk("basic_s1_data", int'(bus.fwd_srcData), 'hA7);
    chk("basic_no_write_yet", int'(bus.write_reg), 0);
    tick();
    chk("basic_write_reg", int'(bus.write_reg), 1);
    chk("basic_rDest", int'(bus.rDest), 3);
    chk("basic_writeData", int'(bus.writeData), 'hA7);
    chk("basic_retire", int'(bus.retire_count), 1);
    chk("basic_s2_hit", int'(bus.fwd_hit), 2);
    tick();
    chk("basic_write_once", int'(bus.write_reg), 0);
    chk("basic_rf_hit", int'(bus.fwd_hit), 0);
    chk("basic_rf_data", int'(bus.fwd_srcData), 'hA7);
  endtask

  task automatic test_priority();
    do_reset();
    bus.rSrc = 3'd5;
    set_ex(1'b1, 1'b1, 3'd5, 8'h11);
    tick();
    set_ex(1'b1, 1'b1, 3'd5, 8'h22);
    tick();
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    chk("prio_s1_data", int'(bus.fwd_srcData), 'h22);
    chk("prio_s1_hit", int'(bus.fwd_hit), 1);
    tick();
    chk("prio_s2_data", int'(bus.fwd_srcData), 'h22);
    chk("prio_s2_hit", int'(bus.fwd_hit), 2);
  endtask

  task automatic test_stall();
    do_reset();
    set_ex(1'b1, 1'b1, 3'd1, 8'h0A);
    tick();
    set_ex(1'b1, 1'b1, 3'd2, 8'h5C);
    tick();
    bus.stall = 1'b1;
    set_ex(1'b1, 1'b1, 3'd7, 8'hFF);
    bus.rSrc = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_write_reg", int'(bus.write_reg), 1);
      chk("stall_rDest", int'(bus.rDest), 1);
      chk("stall_writeData", int'(bus.writeData), 'h0A);
      chk("stall_retire", int'(bus.retire_count), 1);
      chk("stall_s1_hit", int'(bus.fwd_hit), 1);
      chk("stall_s1_data", int'(bus.fwd_srcData), 'h5C);
    end
    bus.stall = 1'b0;
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    chk("unstall_rDest", int'(bus.rDest), 2);
    chk("unstall_writeData", int'(bus.writeData), 'h5C);
    chk("unstall_retire", int'(bus.retire_count), 2);
    bus.rSrc = 3'd7;
    #1;
    chk("stall_ignored_in", int'(bus.fwd_hit), 0);
  endtask

  task automatic test_flush();
    do_reset();
    set_ex(1'b1, 1'b1, 3'd4, 8'h33);
    tick();
    bus.flush = 1'b1;
    set_ex(1'b1, 1'b1, 3'd6, 8'h99);
    tick();
    bus.flush = 1'b0;
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    bus.rSrc = 3'd6;
    #1;
    chk("flush_write_reg", int'(bus.write_reg), 1);
    chk("flush_rDest", int'(bus.rDest), 4);
    chk("flush_writeData", int'(bus.writeData), 'h33);
    chk("flush_retire", int'(bus.retire_count), 1);
    chk("flush_squash_hit", int'(bus.fwd_hit), 0);
    tick();
    chk("flush_no_write6", int'(bus.write_reg), 0);
    // flush together with stall
    set_ex(1'b1, 1'b1, 3'd2, 8'h44);
    tick();
    set_ex(1'b1, 1'b1, 3'd3, 8'h66);
    tick();
    bus.flush = 1'b1; bus.stall = 1'b1;
    tick();
    bus.flush = 1'b0; bus.stall = 1'b0;
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    bus.rSrc = 3'd3;
    #1;
    chk("fs_s2_rDest", int'(bus.rDest), 2);
    chk("fs_s2_data", int'(bus.writeData), 'h44);
    chk("fs_s2_write", int'(bus.write_reg), 1);
    chk("fs_retire", int'(bus.retire_count), 2);
    chk("fs_s1_empty", int'(bus.fwd_hit), 0);
    tick();
    chk("fs_no_write3", int'(bus.write_reg), 0);
    chk("fs_retire_after", int'(bus.retire_count), 2);
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      set_ex(1'b1, 1'b0, 3'(i), 8'(i));
      tick();
    end
    chk("wrap_255", int'(bus.retire_count), 255);
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    chk("wrap_0", int'(bus.retire_count), 0);
    set_ex(1'b1, 1'b1, 3'd5, 8'h77);
    tick();
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    chk("pre_async_write", int'(bus.write_reg), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_write_reg", int'(bus.write_reg), 0);
    chk("async_rDest", int'(bus.rDest), 0);
    #1;
    reset = 1'b0;
    tick();
    chk("async_lost_write", int'(bus.write_reg), 0);
  endtask

  // Random traffic: fwd_srcData must always equal the architectural value
  // (latest accepted write), and the write port must replay accepted writes
  // in program order.
  task automatic test_random();
    logic [7:0] arch [8];
    logic [10:0] exp_q [$];
    logic [10:0] got;
    int   accepted = 0;
    logic pre_w, st, fl;
    logic [2:0] pre_d;
    logic [7:0] pre_x;
    do_reset();
    for (int r = 0; r < 8; r++) arch[r] = tb_rf[r];
    for (int i = 0; i < 400; i++) begin
      if (i < 396) begin
        st = ($urandom % 4) == 0;
        fl = !st && (($urandom % 6) == 0);
        set_ex(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
      end else begin
        st = 1'b0; fl = 1'b0;
        set_ex(1'b0, 1'b0, 3'd0, 8'h00);
      end
      bus.stall = st; bus.flush = fl;
      bus.rSrc = 3'($urandom);
      #1;
      chk("rand_fwd", int'(bus.fwd_srcData), int'(arch[bus.rSrc]));
      pre_w = bus.write_reg; pre_d = bus.rDest; pre_x = bus.writeData;
      @(posedge clk);
      if (!st && !fl && bus.ex_valid) begin
        accepted++;
        if (bus.ex_write_reg) begin
          arch[bus.ex_rDest] = bus.ex_result;
          exp_q.push_back({bus.ex_rDest, bus.ex_result});
        end
      end
      if (!st && pre_w) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious_write", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("rand_write_port", int'({pre_d, pre_x}), int'(got));
        end
      end
      #1;
    end
    chk("rand_writes_drained", exp_q.size(), 0);
    chk("rand_retire", int'(bus.retire_count), accepted % 256);
  endtask

  initial begin
    bus.stall = 1'b0; bus.flush = 1'b0; bus.rSrc = 3'd0;
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    test_reset();
    test_basic_write();
    test_priority();
    test_stall();
    test_flush();
    test_wrap_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
